// File: rtl/dist_scan_pkg.sv
// Shared types and constants for the pair-distance scan engine.
package dist_scan_pkg;

  localparam int unsigned N_VALS    = 32;
  localparam int unsigned N_PAIRS   = N_VALS * (N_VALS - 1) / 2;
  localparam int unsigned LOAD_CYC  = 2 * N_VALS;
  localparam int unsigned WRITE_CYC = 4;

  localparam logic [15:0] MIN_INIT = 16'hFFFF;
  localparam logic [15:0] MAX_INIT = 16'h0000;

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, WRITE, DONE} state_t;

endpackage

// File: rtl/abs_diff16.sv
// Unsigned magnitude of the difference of two signed 16-bit operands.
module abs_diff16 (
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  output logic        [15:0] o_dist
);

  logic signed [16:0] w_diff;
  logic signed [16:0] w_neg;

  // 17 bits hold the full range, so |a-b| <= 65535 always fits in 16.
  assign w_diff = {i_a[15], i_a} - {i_b[15], i_b};
  assign w_neg  = -w_diff;
  assign o_dist = w_diff[16] ? w_neg[15:0] : w_diff[15:0];

endmodule

// File: rtl/dist_scan_engine.sv
// Loads N_VALS big-endian operands, scans every unordered pair for min/max |a-b|,
// then writes both results back as big-endian halfwords.
module dist_scan_engine
  import dist_scan_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MIN_ADDR  = 66,
  parameter int unsigned MAX_ADDR  = 68,
  parameter int unsigned AW        = 8,
  localparam int unsigned IW       = $clog2(N_VALS)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  output logic [AW-1:0] o_mem_addr,
  input  logic [7:0]    i_mem_rd_data,
  output logic          o_mem_wr_en,
  output logic [7:0]    o_mem_wr_data,
  output logic          o_done,
  output logic [IW-1:0] o_min_i,
  output logic [IW-1:0] o_min_j,
  output logic [IW-1:0] o_max_i,
  output logic [IW-1:0] o_max_j
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYC - 1);
  localparam logic [CW-1:0] PAIR_LAST = CW'(N_PAIRS - 1);
  localparam logic [CW-1:0] WR_LAST   = CW'(WRITE_CYC - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_addr;
  logic            r_wr_en;
  logic [7:0]      r_wr_data;
  logic            r_done;
  logic [15:0]     r_min, r_max;
  logic [IW-1:0]   r_min_i, r_min_j, r_max_i, r_max_j;
  logic [IW-1:0]   r_i, r_j;
  logic [15:0]     r_cache [N_VALS];

  logic signed [15:0] w_vi, w_vj;
  logic [15:0]        w_dist;
  logic               w_min_upd, w_max_upd;

  assign w_vi      = r_cache[r_i];
  assign w_vj      = r_cache[r_j];
  assign w_min_upd = (w_dist < r_min);
  assign w_max_upd = (w_dist > r_max);

  abs_diff16 u_abs (
    .i_a    (w_vi),
    .i_b    (w_vj),
    .o_dist (w_dist)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_min     <= MIN_INIT;
      r_max     <= MAX_INIT;
      r_min_i   <= '0;
      r_min_j   <= '0;
      r_max_i   <= '0;
      r_max_j   <= '0;
      r_i       <= '0;
      r_j       <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_addr  <= AW'(BASE_ADDR);
            r_done  <= 1'b0;
            r_min   <= MIN_INIT;
            r_max   <= MAX_INIT;
            r_min_i <= '0;
            r_min_j <= '0;
            r_max_i <= '0;
            r_max_j <= '0;
            r_i     <= '0;
            r_j     <= IW'(1);
          end
        end
        LOAD: begin
          if (r_cnt[0]) r_cache[r_cnt[IW:1]][7:0]  <= i_mem_rd_data;
          else          r_cache[r_cnt[IW:1]][15:8] <= i_mem_rd_data;
          if (r_cnt == LOAD_LAST) begin
            r_state <= SCAN;
            r_cnt   <= '0;
            r_addr  <= '0;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_addr <= r_addr + AW'(1);
          end
        end
        SCAN: begin
          if (w_min_upd) begin
            r_min   <= w_dist;
            r_min_i <= r_i;
            r_min_j <= r_j;
          end
          if (w_max_upd) begin
            r_max   <= w_dist;
            r_max_i <= r_i;
            r_max_j <= r_j;
          end
          if (r_j == IW'(N_VALS - 1)) begin
            r_i <= r_i + IW'(1);
            r_j <= r_i + IW'(2);
          end else begin
            r_j <= r_j + IW'(1);
          end
          // The last pair may still move min, so the first byte uses the bypassed value.
          if (r_cnt == PAIR_LAST) begin
            r_state   <= WRITE;
            r_cnt     <= '0;
            r_addr    <= AW'(MIN_ADDR);
            r_wr_en   <= 1'b1;
            r_wr_data <= w_min_upd ? w_dist[15:8] : r_min[15:8];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WRITE: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == WR_LAST) begin
            r_state   <= DONE;
            r_wr_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b1;
          end else begin
            case (r_cnt[1:0])
              2'd0: begin
                r_addr    <= AW'(MIN_ADDR + 1);
                r_wr_data <= r_min[7:0];
              end
              2'd1: begin
                r_addr    <= AW'(MAX_ADDR);
                r_wr_data <= r_max[15:8];
              end
              default: begin
                r_addr    <= AW'(MAX_ADDR + 1);
                r_wr_data <= r_max[7:0];
              end
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_addr    = r_addr;
  assign o_mem_wr_en   = r_wr_en;
  assign o_mem_wr_data = r_wr_data;
  assign o_done        = r_done;
  assign o_min_i       = r_min_i;
  assign o_min_j       = r_min_j;
  assign o_max_i       = r_max_i;
  assign o_max_j       = r_max_j;

endmodule

// File: tb/tb_dist_scan_engine.sv
// Directed and random checks of dist_scan_engine against a byte-memory model.
module tb_dist_scan_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       done;
  logic [4:0] min_i, min_j, max_i, max_j;

  logic [7:0]  dm      [256];
  logic [7:0]  dm_save [64];
  logic [15:0] v       [32];
  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int n_op_wr = 0;

  always #5 clk = ~clk;

  dist_scan_engine dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .o_mem_addr    (mem_addr),
    .i_mem_rd_data (mem_rd_data),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_wr_data (mem_wr_data),
    .o_done        (done),
    .o_min_i       (min_i),
    .o_min_j       (min_j),
    .o_max_i       (max_i),
    .o_max_j       (max_j)
  );

  assign mem_rd_data = dm[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      dm[mem_addr] = mem_wr_data;
      n_wr++;
      if (mem_addr < 8'd64) n_op_wr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) dm[i] = 8'hA5;
    for (int i = 0; i < 32; i++) begin
      dm[2*i]   = v[i][15:8];
      dm[2*i+1] = v[i][7:0];
    end
    for (int i = 0; i < 64; i++) dm_save[i] = dm[i];
  endtask

  // Pulse start, then count edges until done; glitch>0 re-pulses start mid-run.
  task automatic run(input int glitch, output int cyc, output logic done_after_accept);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_after_accept = done;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == glitch) start = 1'b1;
      else if (cyc == glitch + 1) start = 1'b0;
    end
  endtask

  task automatic model(output logic [15:0] mn, output logic [15:0] mx,
                       output int mni, output int mnj, output int mxi, output int mxj);
    int d;
    mn = 16'hFFFF; mx = 16'h0000;
    mni = 0; mnj = 0; mxi = 0; mxj = 0;
    for (int j = 0; j < 32; j++) begin
      for (int k = j + 1; k < 32; k++) begin
        d = int'($signed(v[j])) - int'($signed(v[k]));
        if (d < 0) d = -d;
        if (d < int'(mn)) begin mn = 16'(d); mni = j; mnj = k; end
        if (d > int'(mx)) begin mx = 16'(d); mxi = j; mxj = k; end
      end
    end
  endtask

  task automatic chk_result(input string tag, input logic [15:0] mn, input logic [15:0] mx,
                            input int mni, input int mnj, input int mxi, input int mxj);
    logic ok_img;
    chk({tag, " min"}, {16'h0, dm[66], dm[67]}, {16'h0, mn});
    chk({tag, " max"}, {16'h0, dm[68], dm[69]}, {16'h0, mx});
    chk({tag, " min_ij"}, {22'h0, min_i, min_j}, 32'(mni * 32 + mnj));
    chk({tag, " max_ij"}, {22'h0, max_i, max_j}, 32'(mxi * 32 + mxj));
    ok_img = 1'b1;
    for (int i = 0; i < 64; i++) if (dm[i] !== dm_save[i]) ok_img = 1'b0;
    chk({tag, " image"}, {31'h0, ok_img}, 32'h1);
  endtask

  initial begin
    int cyc;
    logic dacc;
    logic [15:0] mn, mx;
    int mni, mnj, mxi, mxj;
    int wr_before;

    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) dm[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst done", {31'h0, done}, 32'h0);
    chk("rst wr_en", {31'h0, mem_wr_en}, 32'h0);
    chk("rst addr", {24'h0, mem_addr}, 32'h0);
    chk("rst wr_data", {24'h0, mem_wr_data}, 32'h0);
    chk("rst idx", {12'h0, min_i, min_j, max_i, max_j}, 32'h0);
    reset = 1'b0;

    // 1: all equal
    for (int i = 0; i < 32; i++) v[i] = 16'h1234;
    load_mem();
    run(0, cyc, dacc);
    chk("t1 latency", cyc, 32'd564);
    chk_result("t1", 16'h0000, 16'h0000, 0, 1, 0, 0);
    chk("t1 op writes", n_op_wr, 32'd0);

    // 2: ramp 3*i
    for (int i = 0; i < 32; i++) v[i] = 16'(3 * i);
    load_mem();
    run(0, cyc, dacc);
    chk("t2 latency", cyc, 32'd564);
    chk_result("t2", 16'd3, 16'd93, 0, 1, 0, 31);

    // 3: extreme magnitudes
    for (int i = 0; i < 32; i++) v[i] = 16'h0000;
    v[0] = 16'h8000;
    v[1] = 16'h7FFF;
    load_mem();
    run(0, cyc, dacc);
    chk_result("t3", 16'h0000, 16'hFFFF, 2, 3, 0, 1);

    // 4: random operands
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) v[i] = 16'($urandom);
      load_mem();
      model(mn, mx, mni, mnj, mxi, mxj);
      run(0, cyc, dacc);
      chk("t4 latency", cyc, 32'd564);
      chk_result("t4", mn, mx, mni, mnj, mxi, mxj);
    end
    chk("t4 op writes", n_op_wr, 32'd0);

    // 5: reset at SCAN cycle 300
    for (int i = 0; i < 32; i++) v[i] = 16'(i * 37 - 500);
    load_mem();
    model(mn, mx, mni, mnj, mxi, mxj);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (64 + 300) @(posedge clk);
    #1;
    wr_before = n_wr;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    chk("t5 no writes", n_wr, wr_before);
    chk("t5 done low", {31'h0, done}, 32'h0);
    run(0, cyc, dacc);
    chk("t5 latency", cyc, 32'd564);
    chk_result("t5", mn, mx, mni, mnj, mxi, mxj);

    // 6: start during SCAN ignored; start in DONE restarts
    for (int i = 0; i < 32; i++) v[i] = 16'((i * 7919) ^ 16'h5A5A);
    load_mem();
    model(mn, mx, mni, mnj, mxi, mxj);
    run(100, cyc, dacc);
    chk("t6 glitch latency", cyc, 32'd564);
    chk_result("t6a", mn, mx, mni, mnj, mxi, mxj);
    for (int a = 66; a < 70; a++) dm[a] = 8'hA5;
    run(0, cyc, dacc);
    chk("t6 done drop", {31'h0, dacc}, 32'h0);
    chk("t6 restart latency", cyc, 32'd564);
    chk_result("t6b", mn, mx, mni, mnj, mxi, mxj);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
